// File: rtl/filt_pkg.sv
// ---------------------------------------------------------------------------
// filt_pkg
// Shared widths, saturation bounds and the requantization helper used by
// filt_out_requant. The helper converts a Q22.18 filter sample into a
// Q12.10 output sample with round-half-up and saturation.
// ---------------------------------------------------------------------------
package filt_pkg;

  localparam int IN_W     = 22;
  localparam int IN_FRAC  = 18;
  localparam int OUT_W    = 12;
  localparam int OUT_FRAC = 10;
  localparam int SAT_MAX  = 2047;
  localparam int SAT_MIN  = -2048;

  // Derived widths: one guard bit for the rounding add, then drop SHIFT LSBs.
  localparam int SHIFT = IN_FRAC - OUT_FRAC;
  localparam int SUM_W = IN_W + 1;
  localparam int SHR_W = SUM_W - SHIFT;

  localparam logic signed [SUM_W-1:0] ROUND_ADD = SUM_W'(1 << (SHIFT - 1));
  localparam logic signed [SHR_W-1:0] SHR_MAX   = SHR_W'(SAT_MAX);
  localparam logic signed [SHR_W-1:0] SHR_MIN   = SHR_W'(SAT_MIN);

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             sat;
  } rq_t;

  // Round-half-up at full precision, arithmetic shift, clamp to output range.
  function automatic rq_t requant(input logic [IN_W-1:0] x);
    logic signed [SUM_W-1:0] sum;
    logic signed [SHR_W-1:0] shr;
    rq_t                     r;
    sum = $signed({x[IN_W-1], x}) + ROUND_ADD;
    shr = $signed(sum[SUM_W-1:SHIFT]);
    if (shr > SHR_MAX) begin
      r.data = OUT_W'(SAT_MAX);
      r.sat  = 1'b1;
    end else if (shr < SHR_MIN) begin
      r.data = OUT_W'(SAT_MIN);
      r.sat  = 1'b1;
    end else begin
      r.data = shr[OUT_W-1:0];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// First-word-fall-through FIFO with registered head outputs. A write that
// meets a full FIFO without a simultaneous pop is dropped and flagged on ovf.
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   wr_en, wr_data      write request and data
//   rd_rdy              consumer ready; pop happens on rd_vld & rd_rdy
//   rd_data, rd_vld     registered FIFO head and its valid
//   level               occupancy, 0..DEPTH
//   ovf                 one-cycle pulse after a dropped write
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_vld,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] head_nxt_s;
  logic             vld_r;
  logic             ovf_r;
  logic             pop_s;
  logic             full_s;
  logic             wr_ok_s;
  logic             drop_s;

  // Next-state for pointers, occupancy and the registered head.
  always_comb begin
    pop_s   = vld_r && rd_rdy;
    full_s  = (level_r == LW'(DEPTH));
    wr_ok_s = wr_en && (!full_s || pop_s);
    drop_s  = wr_en && full_s && !pop_s;

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({wr_ok_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase

    // The incoming word becomes the head when it lands at the next read slot
    // (empty FIFO, or the last word being popped).
    if (wr_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy, head register and overflow pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      data_r   <= '0;
      vld_r    <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      vld_r    <= (level_nxt_s != '0);
      if (level_nxt_s != '0) begin
        data_r <= head_nxt_s;
      end
      ovf_r <= drop_s;
    end
  end

  assign rd_data = data_r;
  assign rd_vld  = vld_r;
  assign level   = level_r;
  assign ovf     = ovf_r;

endmodule

// File: rtl/filt_out_requant.sv
// ---------------------------------------------------------------------------
// filt_out_requant
// Decimates the FIR output stream, requantizes kept samples from Q22.18 to
// Q12.10 with saturation, and buffers them in a FWFT FIFO.
// Ports:
//   clk, rstn           clock, asynchronous active-low reset
//   filt_in, filt_vld   filter sample and its valid
//   decim_sel           decimation factor 1/2/4/8
//   sat_clr             clears the sticky sat_flag
//   out_data, out_vld   FIFO head, ready/valid with out_rdy
//   sat_flag            sticky: a kept sample saturated
//   ovf                 pulse: a kept sample was dropped on a full FIFO
//   level               FIFO occupancy
// ---------------------------------------------------------------------------
module filt_out_requant
  import filt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [IN_W-1:0]        filt_in,
  input  logic                   filt_vld,
  input  logic [1:0]             decim_sel,
  input  logic                   sat_clr,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   sat_flag,
  output logic                   ovf,
  output logic [$clog2(DEPTH):0] level
);

  logic [2:0]       cnt_r;
  logic [2:0]       cnt_nxt_s;
  logic [2:0]       cnt_max_s;
  logic [2:0]       cnt_eff_s;
  logic [1:0]       sel_prev_r;
  logic             sel_chg_s;
  logic             keep_s;
  rq_t              rq_s;
  logic             stg_vld_r;
  logic [OUT_W-1:0] stg_data_r;
  logic             sat_flag_r;

  // Decimation decision and requantization of the current input.
  always_comb begin
    case (decim_sel)
      2'd0:    cnt_max_s = 3'd0;
      2'd1:    cnt_max_s = 3'd1;
      2'd2:    cnt_max_s = 3'd3;
      2'd3:    cnt_max_s = 3'd7;
      default: cnt_max_s = 3'd0;
    endcase

    // A factor change restarts the phase immediately, so a sample arriving
    // in the same cycle is already treated as phase 0.
    sel_chg_s = (decim_sel != sel_prev_r);
    if (sel_chg_s) begin
      cnt_eff_s = 3'd0;
    end else begin
      cnt_eff_s = cnt_r;
    end

    keep_s = filt_vld && (cnt_eff_s == 3'd0);

    if (filt_vld) begin
      if (cnt_eff_s >= cnt_max_s) begin
        cnt_nxt_s = 3'd0;
      end else begin
        cnt_nxt_s = cnt_eff_s + 3'd1;
      end
    end else begin
      cnt_nxt_s = cnt_eff_s;
    end

    rq_s = requant(filt_in);
  end

  // Decimation phase counter and decim_sel history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r      <= 3'd0;
      sel_prev_r <= 2'd0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      sel_prev_r <= decim_sel;
    end
  end

  // Stage register for kept samples plus the sticky saturation flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stg_vld_r  <= 1'b0;
      stg_data_r <= '0;
      sat_flag_r <= 1'b0;
    end else begin
      stg_vld_r <= keep_s;
      if (keep_s) begin
        stg_data_r <= rq_s.data;
      end
      if (keep_s && rq_s.sat) begin
        sat_flag_r <= 1'b1;
      end else if (sat_clr) begin
        sat_flag_r <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (stg_vld_r),
    .wr_data (stg_data_r),
    .rd_rdy  (out_rdy),
    .rd_data (out_data),
    .rd_vld  (out_vld),
    .level   (level),
    .ovf     (ovf)
  );

  assign sat_flag = sat_flag_r;

endmodule

// File: tb/tb_filt_out_requant.sv
// ---------------------------------------------------------------------------
// tb_filt_out_requant
// Self-checking bench: a queue-based reference model is stepped on every
// rising edge and compared with all outputs; table vectors, hand-written
// multi-cycle sequences and randomized traffic drive the DUT.
// ---------------------------------------------------------------------------
module tb_filt_out_requant;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [21:0] filt_in;
  logic        filt_vld;
  logic [1:0]  decim_sel;
  logic        sat_clr;
  logic [11:0] out_data;
  logic        out_vld;
  logic        out_rdy;
  logic        sat_flag;
  logic        ovf;
  logic [3:0]  level;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int mq[$];
  bit m_stg_v;
  int m_stg_d;
  int m_cnt;
  int m_prev;
  bit m_sat;
  bit m_ovf;

  typedef struct {
    logic [21:0] din;
    logic [11:0] exp_d;
    bit          exp_s;
  } vec_t;

  vec_t tbl[11];
  int   got[$];
  int   ovf_cnt;

  filt_out_requant #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .filt_in   (filt_in),
    .filt_vld  (filt_vld),
    .decim_sel (decim_sel),
    .sat_clr   (sat_clr),
    .out_data  (out_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .sat_flag  (sat_flag),
    .ovf       (ovf),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Q22.18 -> Q12.10: round half up, floor shift, clamp.
  function automatic int rq(input logic [21:0] x, output bit s);
    int xs;
    int y;
    xs = $signed(x);
    y  = (xs + 128) >>> 8;
    s  = 1'b0;
    if (y > 2047) begin
      y = 2047;
      s = 1'b1;
    end else if (y < -2048) begin
      y = -2048;
      s = 1'b1;
    end
    return y & 32'hFFF;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_stg_v = 1'b0;
    m_stg_d = 0;
    m_cnt   = 0;
    m_prev  = 0;
    m_sat   = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    bit pop;
    bit full;
    bit kept;
    bit s;
    int y;
    pop  = (mq.size() > 0) && out_rdy;
    full = (mq.size() == DEPTH);
    m_ovf = 1'b0;
    if (pop) void'(mq.pop_front());
    if (m_stg_v) begin
      if (full && !pop) m_ovf = 1'b1;
      else mq.push_back(m_stg_d);
    end
    if (int'(decim_sel) != m_prev) m_cnt = 0;
    kept = filt_vld && (m_cnt == 0);
    if (filt_vld) m_cnt = (m_cnt + 1) % (1 << decim_sel);
    m_prev = decim_sel;
    y = rq(filt_in, s);
    m_stg_v = kept;
    if (kept) m_stg_d = y;
    if (kept && s) m_sat = 1'b1;
    else if (sat_clr) m_sat = 1'b0;
  endtask

  task automatic compare_all();
    check("out_vld", out_vld, mq.size() > 0);
    check("level", level, mq.size());
    if (mq.size() > 0) check("out_data", out_data, mq[0]);
    check("ovf", ovf, m_ovf);
    check("sat_flag", sat_flag, m_sat);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    filt_vld = 1'b0;
    sat_clr  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rstn      = 1'b0;
    filt_in   = 22'h0;
    filt_vld  = 1'b0;
    decim_sel = 2'd0;
    sat_clr   = 1'b0;
    out_rdy   = 1'b0;
    model_reset();

    tbl[0]  = '{22'h000180, 12'h002, 1'b0};
    tbl[1]  = '{22'h00017F, 12'h001, 1'b0};
    tbl[2]  = '{22'h1FFFFF, 12'h7FF, 1'b1};
    tbl[3]  = '{22'h000000, 12'h000, 1'b0};
    tbl[4]  = '{22'h200000, 12'h800, 1'b1};
    tbl[5]  = '{22'h3FFF80, 12'h000, 1'b0};
    tbl[6]  = '{22'h3FFF7F, 12'hFFF, 1'b0};
    tbl[7]  = '{22'h07FF7F, 12'h7FF, 1'b0};
    tbl[8]  = '{22'h07FF80, 12'h7FF, 1'b1};
    tbl[9]  = '{22'h380000, 12'h800, 1'b0};
    tbl[10] = '{22'h37FF7F, 12'h800, 1'b1};

    // Reset state
    #12;
    check("rst_level", level, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sat", sat_flag, 0);
    @(negedge clk);
    rstn = 1'b1;
    idle(2);

    // Table vectors: sat_clr alongside the sample, so the flag ends up
    // reflecting only this sample's saturation.
    out_rdy = 1'b1;
    foreach (tbl[i]) begin
      filt_in  = tbl[i].din;
      filt_vld = 1'b1;
      sat_clr  = 1'b1;
      tick();
      check("tbl_sat", sat_flag, tbl[i].exp_s);
      filt_vld = 1'b0;
      sat_clr  = 1'b0;
      tick();
      check("tbl_vld", out_vld, 1);
      check("tbl_data", out_data, tbl[i].exp_d);
      tick();
    end
    // Explicit sat_clr pulse with no sample
    sat_clr = 1'b1;
    tick();
    check("sat_clr", sat_flag, 0);
    sat_clr = 1'b0;

    // Decimation by 4 on a 16-sample ramp
    decim_sel = 2'd2;
    idle(2);
    got.delete();
    for (int k = 0; k < 16; k++) begin
      filt_in  = 22'(k * 256);
      filt_vld = 1'b1;
      tick();
      if (out_vld && out_rdy) got.push_back(out_data);
    end
    filt_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (out_vld && out_rdy) got.push_back(out_data);
    end
    check("decim4_count", got.size(), 4);
    for (int k = 0; k < got.size(); k++) check("decim4_val", got[k], 4 * k);

    // Overflow: 10 kept samples into an 8-deep FIFO with no consumer
    decim_sel = 2'd0;
    out_rdy   = 1'b0;
    idle(2);
    ovf_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      filt_in  = 22'((k + 1) * 768);
      filt_vld = 1'b1;
      tick();
      if (ovf) ovf_cnt++;
    end
    filt_vld = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ovf) ovf_cnt++;
    end
    check("ovf_pulses", ovf_cnt, 2);
    check("full_level", level, 8);
    out_rdy = 1'b1;
    got.delete();
    for (int k = 0; k < 10; k++) begin
      if (out_vld && out_rdy) got.push_back(out_data);
      tick();
    end
    check("drain_count", got.size(), 8);
    for (int k = 0; k < got.size(); k++) check("drain_val", got[k], 3 * (k + 1));

    // Full FIFO with simultaneous pop and write keeps level at DEPTH
    out_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      filt_in  = 22'(k * 300);
      filt_vld = 1'b1;
      tick();
      if (out_rdy) begin
        check("full_rw_level", level, DEPTH);
        check("full_rw_ovf", ovf, 0);
      end
      if (mq.size() == DEPTH) out_rdy = 1'b1;
    end
    idle(12);

    // Asynchronous reset with 5 samples buffered
    out_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      filt_in  = 22'(k * 512);
      filt_vld = 1'b1;
      tick();
    end
    idle(1);
    check("pre_rst_level", level, 5);
    decim_sel = 2'd3;
    idle(1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_level", level, 0);
    check("async_rst_vld", out_vld, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn     = 1'b1;
    filt_in  = 22'h000500;
    filt_vld = 1'b1;
    tick();
    filt_vld = 1'b0;
    tick();
    check("post_rst_vld", out_vld, 1);
    check("post_rst_data", out_data, 5);
    out_rdy = 1'b1;
    idle(3);

    // Randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      filt_vld = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       filt_in = 22'h1FFFFF - 22'($urandom_range(0, 300));
        1:       filt_in = 22'h200000 + 22'($urandom_range(0, 300));
        default: filt_in = 22'($urandom);
      endcase
      if ($urandom_range(0, 39) == 0) decim_sel = 2'($urandom_range(0, 3));
      out_rdy = ($urandom_range(0, 3) != 0);
      if (k % 200 > 150) out_rdy = 1'b0;
      sat_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
